// File: rtl/alu_ctrl_decode_pkg.sv
// Shared ISA definitions for the WISC-SP13 ALU: opcodes, decoder state encoding
// and the control bundle handed from decode to the ALU stage.
package alu_ctrl_decode_pkg;

    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned OPCODE_W = 5;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned CNT_W    = 2;

    localparam logic [OPCODE_W-1:0] OP_HALT  = 5'b00000;
    localparam logic [OPCODE_W-1:0] OP_NOP   = 5'b00001;
    localparam logic [OPCODE_W-1:0] OP_J     = 5'b00100;
    localparam logic [OPCODE_W-1:0] OP_JR    = 5'b00101;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 5'b00110;
    localparam logic [OPCODE_W-1:0] OP_JALR  = 5'b00111;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 5'b01000;
    localparam logic [OPCODE_W-1:0] OP_SUBI  = 5'b01001;
    localparam logic [OPCODE_W-1:0] OP_XORI  = 5'b01010;
    localparam logic [OPCODE_W-1:0] OP_ANDNI = 5'b01011;
    localparam logic [OPCODE_W-1:0] OP_BEQZ  = 5'b01100;
    localparam logic [OPCODE_W-1:0] OP_BNEZ  = 5'b01101;
    localparam logic [OPCODE_W-1:0] OP_BLTZ  = 5'b01110;
    localparam logic [OPCODE_W-1:0] OP_BGEZ  = 5'b01111;
    localparam logic [OPCODE_W-1:0] OP_ST    = 5'b10000;
    localparam logic [OPCODE_W-1:0] OP_LD    = 5'b10001;
    localparam logic [OPCODE_W-1:0] OP_SLBI  = 5'b10010;
    localparam logic [OPCODE_W-1:0] OP_STU   = 5'b10011;
    localparam logic [OPCODE_W-1:0] OP_ROLI  = 5'b10100;
    localparam logic [OPCODE_W-1:0] OP_SLLI  = 5'b10101;
    localparam logic [OPCODE_W-1:0] OP_RORI  = 5'b10110;
    localparam logic [OPCODE_W-1:0] OP_SRLI  = 5'b10111;
    localparam logic [OPCODE_W-1:0] OP_LBI   = 5'b11000;
    localparam logic [OPCODE_W-1:0] OP_SHIFT = 5'b11010;
    localparam logic [OPCODE_W-1:0] OP_ALU   = 5'b11011;
    localparam logic [OPCODE_W-1:0] OP_SEQ   = 5'b11100;
    localparam logic [OPCODE_W-1:0] OP_SLT   = 5'b11101;
    localparam logic [OPCODE_W-1:0] OP_SLE   = 5'b11110;
    localparam logic [OPCODE_W-1:0] OP_SCO   = 5'b11111;

    // R-format function codes in instr[1:0] for OP_ALU
    localparam logic [1:0] FUNC_SUB  = 2'b01;
    localparam logic [1:0] FUNC_ANDN = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    typedef struct packed {
        logic [OPCODE_W-1:0] alu_op;
        logic                inv_a;
        logic                inv_b;
        logic                cin;
        logic [1:0]          lower_two;
        logic [IMM_W-1:0]    imm;
        logic                b_sel_imm;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{OP_NOP, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 1'b0};

endpackage

// File: rtl/alu_ctrl_decode_lut.sv
// Purely combinational instruction-to-ALU-control lookup.
module alu_ctrl_lut
    import alu_ctrl_decode_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output ctrl_t              ctrl_c
);

    logic [OPCODE_W-1:0] opcode;
    logic [1:0]          func;

    always_comb begin
        opcode = instr[15:11];
        func   = instr[1:0];
        ctrl_c = '0;
        ctrl_c.alu_op    = opcode;
        ctrl_c.lower_two = ((opcode == OP_ALU) || (opcode == OP_SHIFT)) ? func : opcode[1:0];

        // Operand inversion / carry-in turn add into subtract or and into and-not
        case (opcode)
            OP_SUBI: begin
                ctrl_c.inv_a = 1'b1;
                ctrl_c.cin   = 1'b1;
            end
            OP_ANDNI: ctrl_c.inv_b = 1'b1;
            OP_ALU: begin
                if (func == FUNC_SUB) begin
                    ctrl_c.inv_a = 1'b1;
                    ctrl_c.cin   = 1'b1;
                end else if (func == FUNC_ANDN) begin
                    ctrl_c.inv_b = 1'b1;
                end
            end
            OP_SEQ, OP_SLT, OP_SLE: begin
                ctrl_c.inv_b = 1'b1;
                ctrl_c.cin   = 1'b1;
            end
            default: ;
        endcase

        case (opcode)
            OP_ADDI, OP_SUBI, OP_ST, OP_LD, OP_STU: begin
                ctrl_c.imm       = {{(IMM_W-5){instr[4]}}, instr[4:0]};
                ctrl_c.b_sel_imm = 1'b1;
            end
            OP_XORI, OP_ANDNI, OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
                ctrl_c.imm       = {(IMM_W-5)'(0), instr[4:0]};
                ctrl_c.b_sel_imm = 1'b1;
            end
            OP_LBI, OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ, OP_JR, OP_JALR: begin
                ctrl_c.imm       = {{(IMM_W-8){instr[7]}}, instr[7:0]};
                ctrl_c.b_sel_imm = 1'b1;
            end
            OP_SLBI: begin
                ctrl_c.imm       = {(IMM_W-8)'(0), instr[7:0]};
                ctrl_c.b_sel_imm = 1'b1;
            end
            OP_J, OP_JAL: begin
                ctrl_c.imm       = {{(IMM_W-11){instr[10]}}, instr[10:0]};
                ctrl_c.b_sel_imm = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_decode.sv
// Decode stage: registers decoded ALU controls in a head/skid buffer with
// valid/ready handshakes, flush, and a terminal HALT state.
module alu_ctrl_decode
    import alu_ctrl_decode_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [INSTR_W-1:0]  in_instr,
    output logic                in_ready,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OPCODE_W-1:0] alu_op,
    output logic                inv_a,
    output logic                inv_b,
    output logic                cin,
    output logic [1:0]          lower_two,
    output logic [IMM_W-1:0]    imm,
    output logic                b_sel_imm,
    output logic                halted
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            head_q, head_d;
    ctrl_t            skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             halted_q, halted_d;
    ctrl_t            dec_c;
    logic             accept, pop;

    alu_ctrl_lut u_lut (
        .instr  (in_instr),
        .ctrl_c (dec_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            cnt_q       <= '0;
            head_q      <= CTRL_IDLE;
            skid_q      <= CTRL_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            halted_q    <= halted_d;
        end
    end

    // Occupancy is tracked separately so HALT can still drain its entries
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        head_d  = head_q;
        skid_d  = skid_q;
        accept  = in_valid & in_ready_q;
        pop     = out_valid_q & out_ready;

        if (flush) begin
            cnt_d   = '0;
            head_d  = CTRL_IDLE;
            state_d = (state_q == ST_HALT) ? ST_HALT : ST_EMPTY;
        end else begin
            if (pop) begin
                head_d = (cnt_q == CNT_W'(2)) ? skid_q : CTRL_IDLE;
                cnt_d  = cnt_q - CNT_W'(1);
            end
            if (accept) begin
                if (cnt_d == '0) begin
                    head_d = dec_c;
                end else begin
                    skid_d = dec_c;
                end
                cnt_d = cnt_d + CNT_W'(1);
            end

            case (state_q)
                ST_HALT: state_d = ST_HALT;
                default: begin
                    if (accept && (dec_c.alu_op == OP_HALT)) begin
                        state_d = ST_HALT;
                    end else if (cnt_d == CNT_W'(2)) begin
                        state_d = ST_TWO;
                    end else if (cnt_d == CNT_W'(1)) begin
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
            endcase
        end

        out_valid_d = (cnt_d != '0);
        in_ready_d  = (state_d == ST_EMPTY) || (state_d == ST_ONE);
        halted_d    = (state_d == ST_HALT);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign halted    = halted_q;
    assign alu_op    = head_q.alu_op;
    assign inv_a     = head_q.inv_a;
    assign inv_b     = head_q.inv_b;
    assign cin       = head_q.cin;
    assign lower_two = head_q.lower_two;
    assign imm       = head_q.imm;
    assign b_sel_imm = head_q.b_sel_imm;

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// Bench for alu_ctrl_decode: directed scenarios plus random traffic against a
// queue-based reference of the buffer and a rule-table decode model.
module tb_alu_ctrl_decode;

    localparam logic [26:0] IDLE = {5'b00001, 22'd0};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_instr = 16'h0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  alu_op;
    logic        inv_a, inv_b, cin;
    logic [1:0]  lower_two;
    logic [15:0] imm;
    logic        b_sel_imm;
    logic        halted;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] mq[$];
    bit          m_halt = 1'b0;
    bit          last_acc, last_pop;

    alu_ctrl_decode dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .alu_op(alu_op), .inv_a(inv_a), .inv_b(inv_b),
        .cin(cin), .lower_two(lower_two), .imm(imm), .b_sel_imm(b_sel_imm),
        .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [26:0] ref_decode(input logic [15:0] i);
        logic [4:0] op;
        logic       ia, ib, c;
        logic [1:0] lo;
        int         w, v;
        bit         sgn;
        op = i[15:11];
        ia = 1'b0; ib = 1'b0; c = 1'b0; w = 0; sgn = 1'b0;
        lo = (op == 5'b11011 || op == 5'b11010) ? i[1:0] : op[1:0];
        if (op == 5'b01001 || (op == 5'b11011 && i[1:0] == 2'b01)) begin ia = 1'b1; c = 1'b1; end
        if (op == 5'b01011 || (op == 5'b11011 && i[1:0] == 2'b11)) ib = 1'b1;
        if (op inside {5'b11100, 5'b11101, 5'b11110}) begin ib = 1'b1; c = 1'b1; end
        if (op inside {5'b01000, 5'b01001, 5'b10000, 5'b10001, 5'b10011}) begin w = 5; sgn = 1'b1; end
        else if (op inside {5'b01010, 5'b01011, [5'b10100:5'b10111]}) w = 5;
        else if (op inside {5'b11000, [5'b01100:5'b01111], 5'b00101, 5'b00111}) begin w = 8; sgn = 1'b1; end
        else if (op == 5'b10010) w = 8;
        else if (op inside {5'b00100, 5'b00110}) begin w = 11; sgn = 1'b1; end
        v = (w == 0) ? 0 : (int'(i) & ((1 << w) - 1));
        if (sgn && w > 0 && v >= (1 << (w - 1))) v = v - (1 << w);
        return {op, ia, ib, c, lo, 16'(v), (w != 0)};
    endfunction

    function automatic logic [26:0] exp_head();
        return (mq.size() > 0) ? ref_decode(mq[0]) : IDLE;
    endfunction

    function automatic logic [26:0] dut_bundle();
        return {alu_op, inv_a, inv_b, cin, lower_two, imm, b_sel_imm};
    endfunction

    function automatic logic [15:0] rand_instr();
        logic [15:0] r;
        r = 16'($urandom);
        if (r[15:11] == 5'd0) r[15:11] = 5'b01000;
        return r;
    endfunction

    // Drive one cycle from a negedge; the model advances at the posedge.
    task automatic cycle(input logic v, input logic [15:0] ins, input logic ordy, input logic fl);
        bit acc, pp;
        logic [15:0] tmp;
        in_valid = v; in_instr = ins; out_ready = ordy; flush = fl;
        acc = v && !m_halt && (mq.size() < 2);
        pp  = (mq.size() > 0) && ordy;
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (pp) tmp = mq.pop_front();
            if (acc) begin
                mq.push_back(ins);
                if (ins[15:11] == 5'd0) m_halt = 1'b1;
            end
        end
        last_acc = acc && !fl;
        last_pop = pp && !fl;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        mq.delete(); m_halt = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || halted !== 1'b0) $display("FAIL reset_flags: out_valid=%b halted=%b want 0/0", out_valid, halted);
        else n_pass++;
        n_checks++;
        if (dut_bundle() !== IDLE) $display("FAIL reset_bundle: got %h want %h", dut_bundle(), IDLE);
        else n_pass++;
        rst = 1'b0;
        mq.delete(); m_halt = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_subi();
        do_reset();
        cycle(1'b1, 16'h4C83, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL subi_valid: got %b want 1", out_valid);
        else n_pass++;
        n_checks++;
        if (dut_bundle() !== {5'b01001, 1'b1, 1'b0, 1'b1, 2'b01, 16'h0003, 1'b1})
            $display("FAIL subi_bundle: got %h want %h", dut_bundle(), {5'b01001, 1'b1, 1'b0, 1'b1, 2'b01, 16'h0003, 1'b1});
        else n_pass++;
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0 || dut_bundle() !== IDLE) $display("FAIL subi_drain: valid=%b bundle=%h want 0/%h", out_valid, dut_bundle(), IDLE);
        else n_pass++;
    endtask

    task automatic test_imm_ext();
        logic [15:0] ins[3];
        logic [15:0] want[3];
        ins[0] = {5'b01000, 6'd0, 5'b10000}; want[0] = 16'hFFF0;
        ins[1] = {5'b01010, 6'd0, 5'b10000}; want[1] = 16'h0010;
        ins[2] = {5'b00100, 11'h400};         want[2] = 16'hFC00;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, ins[k], 1'b1, 1'b0);
            n_checks++;
            if (imm !== want[k] || b_sel_imm !== 1'b1 || out_valid !== 1'b1)
                $display("FAIL imm_ext_%0d: imm=%h bsel=%b valid=%b want %h/1/1", k, imm, b_sel_imm, out_valid, want[k]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] seq[3];
        int  idx;
        bit  c_sent;
        seq[0] = 16'h4C83; seq[1] = 16'hD8E1; seq[2] = 16'h5010;
        do_reset();
        cycle(1'b1, seq[0], 1'b0, 1'b0);
        cycle(1'b1, seq[1], 1'b0, 1'b0);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL bp_full: in_ready=%b valid=%b want 0/1", in_ready, out_valid);
        else n_pass++;
        cycle(1'b1, seq[2], 1'b0, 1'b0);
        n_checks++;
        if (in_ready !== 1'b0 || dut_bundle() !== ref_decode(seq[0])) $display("FAIL bp_hold: in_ready=%b head=%h want 0/%h", in_ready, dut_bundle(), ref_decode(seq[0]));
        else n_pass++;
        idx = 0; c_sent = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid === 1'b1) begin
                n_checks++;
                if (idx < 3 && dut_bundle() === ref_decode(seq[idx])) n_pass++;
                else $display("FAIL bp_order_%0d: got %h want %h", idx, dut_bundle(), (idx < 3) ? ref_decode(seq[idx]) : IDLE);
                idx++;
            end
            cycle(!c_sent, seq[2], 1'b1, 1'b0);
            if (last_acc) c_sent = 1'b1;
        end
        n_checks++;
        if (idx != 3) $display("FAIL bp_count: got %0d entries want 3", idx);
        else n_pass++;
    endtask

    task automatic test_throughput();
        int pops;
        bit ready_ok;
        do_reset();
        pops = 0; ready_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (in_ready !== 1'b1) ready_ok = 1'b0;
            if (out_valid === 1'b1) pops++;
            cycle(1'b1, rand_instr(), 1'b1, 1'b0);
        end
        if (out_valid === 1'b1) pops++;
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        n_checks++;
        if (!ready_ok) $display("FAIL tput_ready: in_ready dropped, want always 1");
        else n_pass++;
        n_checks++;
        if (pops != 10) $display("FAIL tput_pops: got %0d want 10", pops);
        else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        cycle(1'b1, 16'h4123, 1'b0, 1'b0);
        cycle(1'b1, 16'h5234, 1'b0, 1'b0);
        cycle(1'b1, 16'hE345, 1'b0, 1'b1);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut_bundle() !== IDLE)
            $display("FAIL flush_two: valid=%b ready=%b bundle=%h want 0/1/%h", out_valid, in_ready, dut_bundle(), IDLE);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 16'h0, 1'b1, 1'b0);
            n_checks++;
            if (out_valid !== 1'b0) $display("FAIL flush_ghost_%0d: valid=%b want 0", k, out_valid);
            else n_pass++;
        end
        cycle(1'b1, 16'h4123, 1'b0, 1'b0);
        cycle(1'b1, 16'hC0FF, 1'b1, 1'b1);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL flush_one_accept: valid=%b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_halt();
        do_reset();
        cycle(1'b1, 16'hD8E0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0000, 1'b0, 1'b0);
        n_checks++;
        if (halted !== 1'b1 || in_ready !== 1'b0 || dut_bundle() !== ref_decode(16'hD8E0))
            $display("FAIL halt_enter: halted=%b ready=%b head=%h want 1/0/%h", halted, in_ready, dut_bundle(), ref_decode(16'hD8E0));
        else n_pass++;
        cycle(1'b1, 16'h4123, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || alu_op !== 5'b00000 || in_ready !== 1'b0)
            $display("FAIL halt_drain: valid=%b op=%b ready=%b want 1/00000/0", out_valid, alu_op, in_ready);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 16'h4123, 1'b1, 1'b0);
            n_checks++;
            if (out_valid !== 1'b0 || halted !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL halt_parked_%0d: valid=%b halted=%b ready=%b want 0/1/0", k, out_valid, halted, in_ready);
            else n_pass++;
        end
        cycle(1'b0, 16'h0, 1'b0, 1'b1);
        n_checks++;
        if (halted !== 1'b1 || in_ready !== 1'b0) $display("FAIL halt_flush: halted=%b ready=%b want 1/0", halted, in_ready);
        else n_pass++;
        do_reset();
        n_checks++;
        if (halted !== 1'b0 || in_ready !== 1'b1) $display("FAIL halt_exit: halted=%b ready=%b want 0/1", halted, in_ready);
        else n_pass++;
        cycle(1'b1, 16'h4C83, 1'b0, 1'b0);
        cycle(1'b1, 16'hD8E1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || halted !== 1'b0 || dut_bundle() !== IDLE)
            $display("FAIL async_rst: valid=%b halted=%b bundle=%h want 0/0/%h", out_valid, halted, dut_bundle(), IDLE);
        else n_pass++;
        mq.delete(); m_halt = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [15:0] r;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            n_checks++;
            if (out_valid !== (mq.size() > 0)) $display("FAIL rnd_valid @%0d: got %b want %b", k, out_valid, (mq.size() > 0));
            else n_pass++;
            n_checks++;
            if (in_ready !== (!m_halt && mq.size() < 2)) $display("FAIL rnd_ready @%0d: got %b want %b", k, in_ready, (!m_halt && mq.size() < 2));
            else n_pass++;
            n_checks++;
            if (halted !== m_halt) $display("FAIL rnd_halted @%0d: got %b want %b", k, halted, m_halt);
            else n_pass++;
            n_checks++;
            if (dut_bundle() !== exp_head()) $display("FAIL rnd_bundle @%0d: got %h want %h", k, dut_bundle(), exp_head());
            else n_pass++;
            if (m_halt && mq.size() == 0 && $urandom_range(0, 3) == 0) begin
                do_reset();
            end else begin
                r = 16'($urandom);
                if (r[15:11] == 5'd0 && $urandom_range(0, 7) != 0) r[15:11] = 5'b01000;
                cycle($urandom_range(0, 3) != 0, r, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_subi();
        test_imm_ext();
        test_backpressure();
        test_throughput();
        test_flush();
        test_halt();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
